// File: rtl/mem_req_initiator.sv
// mem_req_initiator: cache-side initiator for the rrqst/rrdy/rdrdy/rdacpt/wrqst/wacpt
// four-phase memory protocol on a shared 16-bit bus. Turns single-cycle cache
// requests (read miss, write hit, write miss) into bus handshakes and returns
// four-word line fills, word order 0..3.
// Optional build macro: MEM_TIMEOUT_EN adds a per-wait-state watchdog that aborts
// the transaction and sets a sticky err flag.
module mem_req_initiator #(
  parameter int SYNC_STAGES    = 2,    // must be >= 2
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        fill_valid,
  output logic [1:0]  fill_idx,
  output logic [15:0] fill_data,
  output logic        done,
  output logic        err,
  output logic        rrqst,
  output logic        wrqst,
  output logic        rdacpt,
  input  logic        rrdy,
  input  logic        rdrdy,
  input  logic        wacpt,
  inout  wire  [15:0] data
);

  typedef enum logic [2:0] {
    IDLE, A_REQ, A_REL, W_DATA, W_REL, R_WAIT, R_ACK, DONE
  } state_t;

  state_t      state;
  logic        is_rd;
  logic        is_wr;
  logic [15:0] wdata_q;
  logic [1:0]  idx;
  logic        drive_en;
  logic [15:0] drive_val;

  // Handshake inputs from memory are asynchronous; bit 0 rrdy, 1 rdrdy, 2 wacpt.
  logic [2:0] async_in;
  logic [2:0] sync_out;
  logic       s_rrdy;
  logic       s_rdrdy;
  logic       s_wacpt;

  assign async_in = {wacpt, rdrdy, rrdy};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      // Shift each handshake input through its synchronizer chain.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) chain <= '0;
        else          chain <= {chain[SYNC_STAGES-2:0], async_in[gi]};
      end
      assign sync_out[gi] = chain[SYNC_STAGES-1];
    end
  endgenerate

  assign s_rrdy  = sync_out[0];
  assign s_rdrdy = sync_out[1];
  assign s_wacpt = sync_out[2];

  // The address phase of any write (hit or miss) is acknowledged by wacpt.
  logic ack;
  assign ack = is_wr ? s_wacpt : s_rrdy;

  // Bus is only driven in A_REQ and W_DATA; the release states give a Z gap.
  assign data = drive_en ? drive_val : {16{1'bz}};

  logic timeout_hit;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_reg;
  logic [CNT_W-1:0]   cnt_cur;
  logic               err_reg;

  // Age of the current state: zero on the first cycle after any state change.
  assign cnt_cur     = (state != state_d) ? '0 : cnt_reg;
  assign timeout_hit = (state != IDLE) && (state != DONE) &&
                       (cnt_cur == CNT_W'(TIMEOUT_CYCLES - 1));
  assign err         = err_reg;

  // Track the previous state and count cycles spent in the current one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_d <= IDLE;
      cnt_reg <= '0;
    end else begin
      state_d <= state;
      cnt_reg <= cnt_cur + 1'b1;
    end
  end
`else
  // Without the watchdog every wait is unbounded; the limit is irrelevant here.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
  assign err         = 1'b0;
`endif

  // Protocol FSM; every output is registered and set on the transition into a state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      is_rd      <= 1'b0;
      is_wr      <= 1'b0;
      wdata_q    <= '0;
      idx        <= '0;
      drive_en   <= 1'b0;
      drive_val  <= '0;
      rrqst      <= 1'b0;
      wrqst      <= 1'b0;
      rdacpt     <= 1'b0;
      req_ready  <= 1'b1;
      fill_valid <= 1'b0;
      fill_idx   <= '0;
      fill_data  <= '0;
      done       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      err_reg    <= 1'b0;
`endif
    end else begin
      fill_valid <= 1'b0;
      done       <= 1'b0;
      if (timeout_hit) begin
        rrqst     <= 1'b0;
        wrqst     <= 1'b0;
        rdacpt    <= 1'b0;
        drive_en  <= 1'b0;
        req_ready <= 1'b1;
        state     <= IDLE;
`ifdef MEM_TIMEOUT_EN
        err_reg   <= 1'b1;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (req_valid && (req_rd || req_wr)) begin
              is_rd     <= req_rd;
              is_wr     <= req_wr;
              wdata_q   <= req_wdata;
              idx       <= '0;
              drive_val <= req_addr;
              drive_en  <= 1'b1;
              // A write miss raises both strobes so memory knows a fill follows.
              rrqst     <= req_rd;
              wrqst     <= req_wr;
              req_ready <= 1'b0;
              state     <= A_REQ;
            end
          end
          A_REQ: begin
            if (ack) begin
              rrqst    <= 1'b0;
              wrqst    <= 1'b0;
              drive_en <= 1'b0;
              state    <= A_REL;
            end
          end
          A_REL: begin
            if (!ack) begin
              if (is_wr) begin
                drive_val <= wdata_q;
                drive_en  <= 1'b1;
                wrqst     <= 1'b1;
                state     <= W_DATA;
              end else begin
                state <= R_WAIT;
              end
            end
          end
          W_DATA: begin
            if (s_wacpt) begin
              wrqst    <= 1'b0;
              drive_en <= 1'b0;
              state    <= W_REL;
            end
          end
          W_REL: begin
            if (!s_wacpt) begin
              if (is_rd) begin
                state <= R_WAIT;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
          R_WAIT: begin
            // Memory holds the word until rdacpt, so the raw bus is stable here.
            if (s_rdrdy) begin
              fill_data  <= data;
              fill_idx   <= idx;
              fill_valid <= 1'b1;
              rdacpt     <= 1'b1;
              state      <= R_ACK;
            end
          end
          R_ACK: begin
            if (!s_rdrdy) begin
              rdacpt <= 1'b0;
              if (idx == 2'd3) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                idx   <= idx + 2'd1;
                state <= R_WAIT;
              end
            end
          end
          DONE: begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_req_initiator.sv
// tb_mem_req_initiator: directed bench for mem_req_initiator with a behavioural
// memory (20-unit handshake, 50-unit read latency). Table of transactions plus
// hand-written busy, reset-abort and (with MEM_TIMEOUT_EN) watchdog sequences.
module tb_mem_req_initiator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        fill_valid;
  logic [1:0]  fill_idx;
  logic [15:0] fill_data;
  logic        done;
  logic        err;
  logic        rrqst;
  logic        wrqst;
  logic        rdacpt;
  logic        rrdy;
  logic        rdrdy;
  logic        wacpt;
  wire  [15:0] data;
  logic        mem_drive;
  logic [15:0] mem_data;

  always #5 clk = ~clk;

  assign data = mem_drive ? mem_data : 16'hzzzz;

  mem_req_initiator #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_data(fill_data),
    .done(done), .err(err),
    .rrqst(rrqst), .wrqst(wrqst), .rdacpt(rdacpt),
    .rrdy(rrdy), .rdrdy(rdrdy), .wacpt(wacpt),
    .data(data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural memory ----------------
  // Unwritten words read back as ~address.
  logic [15:0] ram [logic [15:0]];
  logic [15:0] last_addr = '0;
  logic [15:0] last_wdata = '0;
  int          mem_mute = 0;

  function automatic logic [15:0] ram_rd(input logic [15:0] a);
    if (ram.exists(a)) return ram[a];
    return ~a;
  endfunction

  task automatic mem_xact();
    logic [15:0] a;
    logic r, w;
    #20; if (!reset_n) return;
    a = data; r = rrqst; w = wrqst; last_addr = a;
    if (w) begin
      wacpt = 1'b1;
      wait (!wrqst || !reset_n); if (!reset_n) return;
      #20; if (!reset_n) return;
      wacpt = 1'b0;
      wait (wrqst || !reset_n); if (!reset_n) return;
      #20; if (!reset_n) return;
      ram[a] = data; last_wdata = data; wacpt = 1'b1;
      wait (!wrqst || !reset_n); if (!reset_n) return;
      #20; if (!reset_n) return;
      wacpt = 1'b0;
      if (!r) return;
    end else begin
      rrdy = 1'b1;
      wait (!rrqst || !reset_n); if (!reset_n) return;
      #20; if (!reset_n) return;
      rrdy = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      #50; if (!reset_n) return;
      mem_data = ram_rd({a[15:2], 2'(i)}); mem_drive = 1'b1;
      #5; if (!reset_n) return;
      rdrdy = 1'b1;
      wait (rdacpt || !reset_n); if (!reset_n) return;
      #20; if (!reset_n) return;
      rdrdy = 1'b0; mem_drive = 1'b0;
      wait (!rdacpt || !reset_n); if (!reset_n) return;
    end
  endtask

  always begin
    rrdy = 1'b0; rdrdy = 1'b0; wacpt = 1'b0; mem_drive = 1'b0;
    wait (reset_n);
    wait (rrqst || wrqst || !reset_n);
    if (reset_n) begin
      if (mem_mute != 0) wait (!(rrqst || wrqst) || !reset_n);
      else mem_xact();
    end
  end

  // ---------------- monitor ----------------
  int          done_cnt = 0;
  int          fill_cnt = 0;
  int          rr_rises = 0;
  int          wr_rises = 0;
  logic        rr_p = 1'b0;
  logic        wr_p = 1'b0;
  logic [17:0] fills[$];

  always @(negedge clk) begin
    if (fill_valid) begin
      fills.push_back({fill_idx, fill_data});
      fill_cnt <= fill_cnt + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rrqst && !rr_p) rr_rises <= rr_rises + 1;
    if (wrqst && !wr_p) wr_rises <= wr_rises + 1;
    rr_p <= rrqst;
    wr_p <= wrqst;
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic             rd;
    logic             wr;
    logic [15:0]      addr;
    logic [15:0]      wdata;
    int               nfill;
    int               n_rr;
    int               n_wr;
    logic [3:0][15:0] w;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] addr,
                              input logic [15:0] wdata, input int nfill, input int n_rr,
                              input int n_wr, input logic [15:0] w0, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] w3);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.nfill = nfill; v.n_rr = n_rr; v.n_wr = n_wr;
    v.w = {w3, w2, w1, w0};
    return v;
  endfunction

  task automatic issue(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    check("req_ready_before_issue", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_rd = rd; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_rd = 1'b0; req_wr = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 3000) begin @(negedge clk); n++; end
    check("done_within_budget", {31'd0, (done_cnt != base)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int b_done, b_fill, b_rr, b_wr, fq;
    b_done = done_cnt; b_fill = fill_cnt; b_rr = rr_rises; b_wr = wr_rises; fq = fills.size();
    issue(v.rd, v.wr, v.addr, v.wdata);
    wait_done(b_done);
    check($sformatf("t%0d_done_count", id), done_cnt - b_done, 1);
    check($sformatf("t%0d_fill_count", id), fill_cnt - b_fill, v.nfill);
    check($sformatf("t%0d_rrqst_pulses", id), rr_rises - b_rr, v.n_rr);
    check($sformatf("t%0d_wrqst_pulses", id), wr_rises - b_wr, v.n_wr);
    check($sformatf("t%0d_bus_addr", id), {16'd0, last_addr}, {16'd0, v.addr});
    for (int k = 0; k < v.nfill && fq + k < fills.size(); k++)
      check($sformatf("t%0d_fill%0d", id, k), {14'd0, fills[fq + k]}, {14'd0, 2'(k), v.w[k]});
    if (v.wr) begin
      check($sformatf("t%0d_wdata_on_bus", id), {16'd0, last_wdata}, {16'd0, v.wdata});
      check($sformatf("t%0d_ram_written", id), {16'd0, ram_rd(v.addr)}, {16'd0, v.wdata});
    end
    check($sformatf("t%0d_req_ready_idle", id), {31'd0, req_ready}, 32'd1);
    check($sformatf("t%0d_err_clear", id), {31'd0, err}, 32'd0);
    $display("txn %0d rd=%0b wr=%0b addr=%h fills=%0d dones=%0d", id, v.rd, v.wr, v.addr,
             fill_cnt - b_fill, done_cnt - b_done);
  endtask

  vec_t vecs[7];

  initial begin
    int b_done, b_fill, b_wr, n;
    vecs[0] = mk(1, 0, 16'h1236, 16'h0000, 4, 1, 0, 16'hEDCB, 16'hEDCA, 16'hEDC9, 16'hEDC8);
    vecs[1] = mk(0, 1, 16'h00A0, 16'hBEEF, 0, 0, 2, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[2] = mk(1, 1, 16'h4001, 16'h5555, 4, 1, 2, 16'hBFFF, 16'h5555, 16'hBFFD, 16'hBFFC);
    vecs[3] = mk(1, 0, 16'h00A3, 16'h0000, 4, 1, 0, 16'hBEEF, 16'hFF5E, 16'hFF5D, 16'hFF5C);
    vecs[4] = mk(0, 1, 16'h0000, 16'h0001, 0, 0, 2, 16'h0, 16'h0, 16'h0, 16'h0);
    vecs[5] = mk(1, 0, 16'hFFFF, 16'h0000, 4, 1, 0, 16'h0003, 16'h0002, 16'h0001, 16'h0000);
    vecs[6] = mk(1, 0, 16'h0001, 16'h0000, 4, 1, 0, 16'h0001, 16'hFFFE, 16'hFFFD, 16'hFFFC);

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_outputs", {26'd0, rrqst, wrqst, rdacpt, fill_valid, done, err}, 32'd0);
    check("rst_fill_idx", {30'd0, fill_idx}, 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Valid with neither rd nor wr is ignored
    b_done = done_cnt;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("null_req_no_strobe", rr_rises + wr_rises, 0);
    check("null_req_ready", {31'd0, req_ready}, 32'd1);
    check("null_req_no_done", done_cnt - b_done, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Request while busy in the middle of a read fill
    b_done = done_cnt; b_fill = fill_cnt; b_wr = wr_rises;
    issue(1'b1, 1'b0, 16'h1236, 16'h0000);
    n = 0;
    while (fill_cnt == b_fill && n < 2000) begin @(negedge clk); n++; end
    check("busy_first_fill_seen", {31'd0, (fill_cnt != b_fill)}, 32'd1);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0010; req_wdata = 16'h1111;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy_req_ready_%0d", k), {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0; req_wr = 1'b0;
    wait_done(b_done);
    repeat (20) @(negedge clk);
    check("busy_single_done", done_cnt - b_done, 1);
    check("busy_fill_count", fill_cnt - b_fill, 4);
    check("busy_no_write", wr_rises - b_wr, 0);
    check("busy_ram_untouched", {31'd0, ram.exists(16'h0010)}, 32'd0);
    $display("txn busy: dones=%0d fills=%0d", done_cnt - b_done, fill_cnt - b_fill);

    // Reset during R_ACK after word 1
    b_done = done_cnt; b_fill = fill_cnt;
    issue(1'b1, 1'b0, 16'h2000, 16'h0000);
    n = 0;
    while (!(fill_cnt - b_fill >= 2 && rdacpt) && n < 2000) begin @(negedge clk); n++; end
    check("abort_reached_r_ack", {31'd0, (fill_cnt - b_fill >= 2 && rdacpt)}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs_low", {27'd0, rrqst, wrqst, rdacpt, fill_valid, done}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    check("abort_fill_idx", {30'd0, fill_idx}, 32'd0);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt - b_done, 0);
    check("abort_fill_count", fill_cnt - b_fill, 2);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("txn abort: fills before reset=%0d dones=%0d", fill_cnt - b_fill, done_cnt - b_done);
    run_vec(mk(1, 0, 16'h2000, 16'h0, 4, 1, 0, 16'hDFFF, 16'hDFFE, 16'hDFFD, 16'hDFFC), 7);

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: watchdog must abort after 64 cycles in A_REQ
    mem_mute = 1;
    b_done = done_cnt;
    issue(1'b1, 1'b0, 16'h3000, 16'h0000);
    repeat (60) @(negedge clk);
    check("tmo_still_waiting", {30'd0, rrqst, err}, 32'h2);
    repeat (10) @(negedge clk);
    check("tmo_rrqst_dropped", {31'd0, rrqst}, 32'd0);
    check("tmo_err_set", {31'd0, err}, 32'd1);
    check("tmo_idle", {31'd0, req_ready}, 32'd1);
    check("tmo_no_done", done_cnt - b_done, 0);
    repeat (10) @(negedge clk);
    check("tmo_err_sticky", {31'd0, err}, 32'd1);
    mem_mute = 0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("tmo_err_cleared", {31'd0, err}, 32'd0);
    reset_n = 1'b1;
    $display("txn timeout: err=%0b dones=%0d", err, done_cnt - b_done);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_watchdog: got timeout expected completion");
    $fatal(1, "simulation did not complete");
  end

endmodule
